// File: rtl/lap_stopwatch_core.sv
// Stopwatch engine: tick divider, STOP/RUN/LAP control and an N-digit BCD
// time counter with a lap snapshot that freezes the display while counting continues.
module lap_stopwatch_core #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int DIGITS   = 4,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_run_stop,
    input  logic                  i_clear,
    input  logic                  i_lap,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_running,
    output logic                  o_lap_hold,
    output logic                  o_overflow
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int W     = 4 * DIGITS;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        STOP,
        RUN,
        LAP
    } state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] divider, divider_next;
    logic [W-1:0]     count, count_next;
    logic [W-1:0]     snapshot, snapshot_next;
    logic             overflow_next;
    logic             running_now;
    logic             tick;

    // Ripple a +1 through the digits; each digit rolls 9->0 and carries upward.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] value);
        logic [W-1:0] result;
        logic         carry;
        logic [3:0]   digit;
        result = value;
        carry  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            digit = value[4*k +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    digit = 4'd0;
                end else begin
                    digit = digit + 4'd1;
                    carry = 1'b0;
                end
            end
            result[4*k +: 4] = digit;
        end
        return result;
    endfunction

    function automatic logic all_nines(input logic [W-1:0] value);
        logic nines;
        nines = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (value[4*k +: 4] != 4'd9) begin
                nines = 1'b0;
            end
        end
        return nines;
    endfunction

    assign running_now = (state == RUN) || (state == LAP);
    assign tick        = running_now && (divider == DIV_LAST);

    always_comb begin
        state_next    = state;
        divider_next  = divider;
        count_next    = count;
        snapshot_next = snapshot;
        overflow_next = o_overflow;

        if (running_now) begin
            divider_next = tick ? '0 : divider + DIV_W'(1);
        end

        if (tick) begin
            if (all_nines(count)) begin
                overflow_next = 1'b1;
                count_next    = (SATURATE != 0) ? count : '0;
            end else begin
                count_next = bcd_inc(count);
            end
        end

        // Only the highest-priority pulse that is legal in this state acts.
        case (state)
            STOP: begin
                if (i_clear) begin
                    count_next    = '0;
                    divider_next  = '0;
                    overflow_next = 1'b0;
                end else if (i_run_stop) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (i_run_stop) begin
                    state_next = STOP;
                end else if (i_lap) begin
                    state_next    = LAP;
                    snapshot_next = count;
                end
            end
            LAP: begin
                if (i_run_stop) begin
                    state_next = STOP;
                end else if (i_lap) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = STOP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= STOP;
            divider    <= '0;
            count      <= '0;
            snapshot   <= '0;
            o_overflow <= 1'b0;
            o_bcd      <= '0;
            o_running  <= 1'b0;
            o_lap_hold <= 1'b0;
        end else begin
            state      <= state_next;
            divider    <= divider_next;
            count      <= count_next;
            snapshot   <= snapshot_next;
            o_overflow <= overflow_next;
            o_bcd      <= (state_next == LAP) ? snapshot_next : count_next;
            o_running  <= (state_next != STOP);
            o_lap_hold <= (state_next == LAP);
        end
    end

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Bench for lap_stopwatch_core: three instances (2 digits wrap, 2 digits saturate,
// 4 digits wrap) share one stimulus stream and are checked against an integer model.
module tb_lap_stopwatch_core;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_stop, clear, lap;
    logic [7:0]  bcd_a, bcd_s;
    logic [15:0] bcd_w;
    logic        running_a, running_s, running_w;
    logic        hold_a, hold_s, hold_w;
    logic        ovf_a, ovf_s, ovf_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lap_stopwatch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(2), .SATURATE(0)) dut_a (
        .clk(clk), .reset(reset), .i_run_stop(run_stop), .i_clear(clear), .i_lap(lap),
        .o_bcd(bcd_a), .o_running(running_a), .o_lap_hold(hold_a), .o_overflow(ovf_a));

    lap_stopwatch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(2), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .i_run_stop(run_stop), .i_clear(clear), .i_lap(lap),
        .o_bcd(bcd_s), .o_running(running_s), .o_lap_hold(hold_s), .o_overflow(ovf_s));

    lap_stopwatch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(4), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .i_run_stop(run_stop), .i_clear(clear), .i_lap(lap),
        .o_bcd(bcd_w), .o_running(running_w), .o_lap_hold(hold_w), .o_overflow(ovf_w));

    logic [15:0] act_bcd [3];
    logic        act_run [3];
    logic        act_hold[3];
    logic        act_ovf [3];
    assign act_bcd[0]  = {8'h00, bcd_a};
    assign act_bcd[1]  = {8'h00, bcd_s};
    assign act_bcd[2]  = bcd_w;
    assign act_run[0]  = running_a;
    assign act_run[1]  = running_s;
    assign act_run[2]  = running_w;
    assign act_hold[0] = hold_a;
    assign act_hold[1] = hold_s;
    assign act_hold[2] = hold_w;
    assign act_ovf[0]  = ovf_a;
    assign act_ovf[1]  = ovf_s;
    assign act_ovf[2]  = ovf_w;

    // Reference model: plain integer time value, cycle phase and a mode number
    // (0 stopped, 1 running, 2 running with frozen display).
    int cfg_digits[3] = '{2, 2, 4};
    int cfg_sat[3]    = '{0, 1, 0};
    int m_mode[3];
    int m_phase[3];
    int m_cnt[3];
    int m_snap[3];
    bit m_ovf[3];

    function automatic int pow10(input int d);
        int r = 1;
        for (int k = 0; k < d; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int value, input int digits);
        logic [15:0] r = '0;
        int v = value;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_phase[i] = 0; m_cnt[i] = 0; m_snap[i] = 0; m_ovf[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit rs, input bit cl, input bit lp);
        int old_cnt, top;
        for (int i = 0; i < 3; i++) begin
            old_cnt = m_cnt[i];
            top     = pow10(cfg_digits[i]) - 1;
            if (m_mode[i] != 0) begin
                if (m_phase[i] == DIV - 1) begin
                    if (m_cnt[i] == top) begin
                        m_ovf[i] = 1'b1;
                        m_cnt[i] = (cfg_sat[i] != 0) ? top : 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
                m_phase[i] = (m_phase[i] + 1) % DIV;
            end
            if (m_mode[i] == 0) begin
                if (cl) begin
                    m_cnt[i] = 0; m_phase[i] = 0; m_ovf[i] = 1'b0;
                end else if (rs) begin
                    m_mode[i] = 1;
                end
            end else if (rs) begin
                m_mode[i] = 0;
            end else if (lp) begin
                if (m_mode[i] == 1) m_snap[i] = old_cnt;
                m_mode[i] = (m_mode[i] == 1) ? 2 : 1;
            end
        end
    endtask

    task automatic check_eq(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output(input string tag);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("%s dut%0d bcd", tag, i), act_bcd[i],
                     to_bcd((m_mode[i] == 2) ? m_snap[i] : m_cnt[i], cfg_digits[i]));
            check_eq($sformatf("%s dut%0d running", tag, i), 16'(act_run[i]), 16'(m_mode[i] != 0));
            check_eq($sformatf("%s dut%0d hold", tag, i), 16'(act_hold[i]), 16'(m_mode[i] == 2));
            check_eq($sformatf("%s dut%0d ovf", tag, i), 16'(act_ovf[i]), 16'(m_ovf[i]));
        end
    endtask

    // Called at a falling edge; drives one cycle of pulses and returns at the next falling edge.
    task automatic apply_stimulus(input bit rs, input bit cl, input bit lp);
        run_stop = rs; clear = cl; lap = lp;
        @(posedge clk);
        model_step(rs, cl, lp);
        @(negedge clk);
        run_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) apply_stimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit         rs;
        bit         cl;
        bit         lp;
        int         cycles;
        logic [7:0] bcd;
        bit         run;
        bit         hold;
        bit         ovf;
    } vec_t;

    vec_t vecs[23];

    initial begin
        vecs[0]  = '{0, 0, 0,   1, 8'h00, 0, 0, 0};
        vecs[1]  = '{1, 0, 0,   1, 8'h00, 1, 0, 0};
        vecs[2]  = '{0, 0, 0,   9, 8'h00, 1, 0, 0};
        vecs[3]  = '{0, 0, 0,   1, 8'h01, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 240, 8'h25, 1, 0, 0};
        vecs[5]  = '{0, 1, 0,   1, 8'h25, 1, 0, 0};
        vecs[6]  = '{1, 0, 0,   1, 8'h25, 0, 0, 0};
        vecs[7]  = '{0, 0, 0,  20, 8'h25, 0, 0, 0};
        vecs[8]  = '{0, 1, 0,   1, 8'h00, 0, 0, 0};
        vecs[9]  = '{1, 0, 0,   1, 8'h00, 1, 0, 0};
        vecs[10] = '{0, 0, 0,   9, 8'h00, 1, 0, 0};
        vecs[11] = '{0, 0, 0,   1, 8'h01, 1, 0, 0};
        vecs[12] = '{0, 0, 0, 110, 8'h12, 1, 0, 0};
        vecs[13] = '{0, 0, 1,   1, 8'h12, 1, 1, 0};
        vecs[14] = '{0, 0, 0,  49, 8'h12, 1, 1, 0};
        vecs[15] = '{0, 0, 1,   1, 8'h17, 1, 0, 0};
        vecs[16] = '{0, 0, 1,   1, 8'h17, 1, 1, 0};
        vecs[17] = '{0, 0, 0,  30, 8'h17, 1, 1, 0};
        vecs[18] = '{1, 0, 0,   1, 8'h20, 0, 0, 0};
        vecs[19] = '{1, 0, 0,   1, 8'h20, 1, 0, 0};
        vecs[20] = '{1, 0, 1,   1, 8'h20, 0, 0, 0};
        vecs[21] = '{1, 1, 0,   1, 8'h00, 0, 0, 0};
        vecs[22] = '{0, 0, 0,   5, 8'h00, 0, 0, 0};

        reset = 1'b1; run_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_output("reset");
        reset = 1'b0;

        // Directed scenario on the 2-digit wrapping instance, expected values hand-derived.
        for (int v = 0; v < 23; v++) begin
            apply_stimulus(vecs[v].rs, vecs[v].cl, vecs[v].lp);
            idle(vecs[v].cycles - 1);
            check_eq($sformatf("vec%0d bcd", v), {8'h00, bcd_a}, {8'h00, vecs[v].bcd});
            check_eq($sformatf("vec%0d running", v), 16'(running_a), 16'(vecs[v].run));
            check_eq($sformatf("vec%0d hold", v), 16'(hold_a), 16'(vecs[v].hold));
            check_eq($sformatf("vec%0d ovf", v), 16'(ovf_a), 16'(vecs[v].ovf));
            check_output($sformatf("vec%0d model", v));
        end

        // Random pulse traffic against the model.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            apply_stimulus($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0,
                           $urandom_range(0, 39) == 0);
            check_output("random");
        end

        // Overflow: wrap vs saturate, then stop and clear.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0);
        idle(1004);
        check_eq("ovf wrap bcd", {8'h00, bcd_a}, 16'h0000);
        check_eq("ovf wrap flag", 16'(ovf_a), 16'h0001);
        check_eq("ovf sat bcd", {8'h00, bcd_s}, 16'h0099);
        check_eq("ovf sat flag", 16'(ovf_s), 16'h0001);
        check_eq("ovf wide bcd", bcd_w, 16'h0100);
        check_eq("ovf wide flag", 16'(ovf_w), 16'h0000);
        check_output("overflow");
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_eq("ovf clear wrap flag", 16'(ovf_a), 16'h0000);
        check_eq("ovf clear sat flag", 16'(ovf_s), 16'h0000);
        check_eq("ovf clear sat bcd", {8'h00, bcd_s}, 16'h0000);
        check_output("ovf cleared");

        // Four-digit carry chain 0999 -> 1000.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0);
        idle(9990);
        check_eq("carry 0999", bcd_w, 16'h0999);
        idle(10);
        check_eq("carry 1000", bcd_w, 16'h1000);
        check_output("carry");

        // Asynchronous reset between edges while in LAP.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0);
        idle(130);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        idle(20);
        check_output("pre-reset lap");
        #2 reset = 1'b1;
        #1;
        check_eq("async reset bcd", {8'h00, bcd_a}, 16'h0000);
        check_eq("async reset running", 16'(running_a), 16'h0000);
        check_eq("async reset hold", 16'(hold_a), 16'h0000);
        check_eq("async reset wide bcd", bcd_w, 16'h0000);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        idle(9);
        check_eq("restart 00", {8'h00, bcd_a}, 16'h0000);
        idle(1);
        check_eq("restart 01", {8'h00, bcd_a}, 16'h0001);
        check_output("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
